oka_seq_8bit: RTL and testbench
===============================

# oka_seq_8bit

Multi-cycle sequencer that computes an 8×8 carry-less (GF(2) polynomial) product by time-sharing one external 4-bit OKA multiplier core three times.
- Products formed: low, high and middle Karatsuba terms.
- Operands arrive on a valid/ready input channel; the 15-bit result leaves on a valid/ready output channel.
- Sits between the field-arithmetic front end and a single combinational or registered `OKA_4bit` instance that it drives directly.

## Interface
- `CORE_LAT`, default 0: pipeline latency of the attached core, in cycles. Legal range 0..3.
- `clk`  in  1  clock; all state changes on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `in_valid`  in  1  operand pair valid
- `in_ready`  out  1  block can accept operands this cycle
- `in_a`  in  8  operand A (bit i = coefficient of x^i)
- `in_b`  in  8  operand B
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer takes result this cycle
- `out_y`  out  15  carry-less product A·B
- `busy`  out  1  high in any state other than IDLE
- `core_a`  out  4  operand to shared OKA core
- `core_b`  out  4  operand to shared OKA core
- `core_y`  in  7  product from shared OKA core
- `in_clr`  in  1  accumulator clear; present only with `OKA_SEQ_ACC_EN`

## Operation
- **Notation:** aL/aH, bL/bH are the low/high nibbles of the latched operands. pl, ph, pm are 7-bit product registers.
- **FSM:** IDLE → PL → PH → PM → DONE.
- **Accept:** a handshake occurs when `in_valid && in_ready`. It latches `in_a`/`in_b` and moves the FSM to PL.
- **PL:** drive `core_a=aL`, `core_b=bL`; sample `core_y` into pl.
- **PH:** drive aH, bH; sample into ph.
- **PM:** drive aL^aH, bL^bH; sample into pm. Then go to DONE.
- **Dwell per phase:** each of PL/PH/PM lasts 1+CORE_LAT cycles. Core inputs are held constant for the whole phase; `core_y` is sampled on the last edge of the phase. Use an internal phase counter.
- **Result:** `out_y = (ph<<8) ^ ((pm^pl^ph)<<4) ^ pl`, all XOR, no carries. The result is registered on entry to DONE.
- **DONE:** `out_valid=1`. `out_y` holds stable until `out_ready`.
- **`in_ready`:** equals `(state==IDLE) || (state==DONE && out_ready)`.
- **Simultaneous output and input handshake in DONE:** the result is retired and the new operands are accepted on the same edge; next state is PL, with no idle bubble.
- **DONE with `out_ready` and no `in_valid`:** go to IDLE.
- **`core_a`/`core_b`:** both 0 in IDLE and DONE.
- **Ignored inputs:** `in_valid` while busy is ignored; operands are not latched.
- **Handshake rule:** `out_valid` never deasserts without `out_ready`.

## Timing
- **Reset (`rst_n` low at a rising edge):**
  - state=IDLE.
  - `out_valid=0`, `out_y=0`, `busy=0`, `core_a=0`, `core_b=0`.
  - pl/ph/pm and the accumulator are cleared.
  - `in_ready=1` from the first cycle after reset releases.
- **Reset mid-operation:** the in-flight operation is discarded and no result is emitted.
- **Latency:** with the accept on edge t, `out_valid` rises after edge t+3·(1+CORE_LAT).
- **Throughput:** one result every 3·(1+CORE_LAT)+1 cycles with `out_ready` tied high.
- **Backpressure:** DONE may last indefinitely; the core is idle meanwhile.
- **Core timing:** the core sees new operands one edge after the phase is entered. For CORE_LAT=0, `core_y` is combinational from `core_a`/`core_b`.

## Configuration
- **`OKA_SEQ_ACC_EN` defined:**
  - Adds the `in_clr` input, sampled together with the operands at accept.
  - The result register becomes a GF(2) accumulator: `out_y = (in_clr ? 0 : previous out_y) ^ product`.
  - Enables multiply-accumulate for polynomial dot products.
  - The accumulator persists across idle periods and is cleared only by reset or `in_clr`.
- **Not defined:**
  - No `in_clr` port.
  - `out_y` is the plain product of the current operands.

## Test plan
- **Single product, CORE_LAT=0:** `in_a=8'h0D`, `in_b=8'h0A` → `out_y=15'h0072`, exactly 3 cycles after accept.
- **Full-width and top-bit cases:**
  - `8'hFF`×`8'hFF` → `15'h5555`.
  - `8'h80`×`8'h80` → `15'h4000`.
  - `8'hA5`×`8'h01` → `15'h00A5`.
- **Back-to-back with `out_ready` high:** a new operand pair is accepted in the DONE cycle; results arrive every 4 cycles with no bubble. Then hold `out_ready=0` for 5 cycles: `out_y` stays stable and `in_ready` stays 0.
- **CORE_LAT=2 with a registered-core model:** `8'h0D`×`8'h0A` → `15'h0072` after 9 cycles. `core_a`/`core_b` are held 3 cycles per phase.
- **Reset mid-operation:** assert `rst_n=0` during PH → all outputs 0 the next cycle. After release, the first result corresponds only to newly accepted operands.
- **With `OKA_SEQ_ACC_EN`:** `8'h0D`×`8'h0A` with `in_clr=1`, then `8'h80`×`8'h80` with `in_clr=0` → second result `15'h4072`.

Source files
------------

// File: rtl/oka_seq_8bit.sv
// 8x8 carry-less multiplier sequencer: three Karatsuba passes over one shared 4-bit OKA core.
// Optional GF(2) multiply-accumulate result register is enabled by defining OKA_SEQ_ACC_EN.
module oka_seq_8bit #(
   parameter int unsigned CORE_LAT = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_a,
   input  logic [7:0]  in_b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [14:0] out_y,
   output logic        busy,
   output logic [3:0]  core_a,
   output logic [3:0]  core_b,
   input  logic [6:0]  core_y
`ifdef OKA_SEQ_ACC_EN
   ,
   input  logic        in_clr
`endif
);

   typedef enum logic [2:0] {
      IDLE,
      PL,
      PH,
      PM,
      DONE
   } state_t;

   localparam logic [1:0] LAST = 2'(CORE_LAT);

   state_t      state, state_nx;
   logic [1:0]  cnt;
   logic [7:0]  a_q, b_q;
   logic [6:0]  pl, ph;
   logic [14:0] y_q;
   logic [14:0] prod;
   logic        accept;
   logic        phase_last;
   logic        in_phase;

`ifdef OKA_SEQ_ACC_EN
   logic        clr_q;
`endif

   assign phase_last = (cnt == LAST);
   assign in_phase   = (state == PL) || (state == PH) || (state == PM);
   assign accept     = in_valid && in_ready;

   // The middle term is folded in straight from core_y on the last PM edge,
   // so it never needs its own register.
   assign prod = {ph, 8'b0} ^ {4'b0, core_y ^ pl ^ ph, 4'b0} ^ {8'b0, pl};

   always_comb begin
      state_nx  = state;
      core_a    = '0;
      core_b    = '0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = (state != IDLE);
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = PL;
         end
         PL: begin
            core_a = a_q[3:0];
            core_b = b_q[3:0];
            if (phase_last) state_nx = PH;
         end
         PH: begin
            core_a = a_q[7:4];
            core_b = b_q[7:4];
            if (phase_last) state_nx = PM;
         end
         PM: begin
            core_a = a_q[3:0] ^ a_q[7:4];
            core_b = b_q[3:0] ^ b_q[7:4];
            if (phase_last) state_nx = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
            if (out_ready) state_nx = in_valid ? PL : IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         a_q   <= '0;
         b_q   <= '0;
         pl    <= '0;
         ph    <= '0;
         y_q   <= '0;
`ifdef OKA_SEQ_ACC_EN
         clr_q <= 1'b0;
`endif
      end else begin
         state <= state_nx;
         if (in_phase && !phase_last) cnt <= cnt + 2'd1;
         else                         cnt <= '0;
         if (accept) begin
            a_q <= in_a;
            b_q <= in_b;
`ifdef OKA_SEQ_ACC_EN
            clr_q <= in_clr;
`endif
         end
         if (state == PL && phase_last) pl <= core_y;
         if (state == PH && phase_last) ph <= core_y;
         if (state == PM && phase_last) begin
`ifdef OKA_SEQ_ACC_EN
            y_q <= (clr_q ? '0 : y_q) ^ prod;
`else
            y_q <= prod;
`endif
         end
      end
   end

   assign out_y = y_q;

endmodule

// File: tb/tb_oka_seq_8bit.sv
// Directed bench for oka_seq_8bit: one DUT with a combinational core (CORE_LAT=0),
// one with a two-stage registered core (CORE_LAT=2).
module tb_oka_seq_8bit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   int          n_cmp = 0;
   int          n_bad = 0;

   logic        in_valid0, in_ready0, out_valid0, out_ready0, busy0;
   logic [7:0]  in_a0, in_b0;
   logic [14:0] out_y0;
   logic [3:0]  core_a0, core_b0;
   logic [6:0]  core_y0;

   logic        in_valid2, in_ready2, out_valid2, out_ready2, busy2;
   logic [7:0]  in_a2, in_b2;
   logic [14:0] out_y2;
   logic [3:0]  core_a2, core_b2;
   logic [6:0]  core_y2;
   logic [6:0]  p1, p2;

`ifdef OKA_SEQ_ACC_EN
   logic        in_clr0, in_clr2;
`endif

   function automatic logic [6:0] clmul4(input logic [3:0] a, input logic [3:0] b);
      logic [6:0] r;
      r = '0;
      for (int i = 0; i < 4; i++)
         if (b[i]) r = r ^ ({3'b0, a} << i);
      return r;
   endfunction

   assign core_y0 = clmul4(core_a0, core_b0);

   always @(posedge clk) begin
      p1 <= clmul4(core_a2, core_b2);
      p2 <= p1;
   end
   assign core_y2 = p2;

   oka_seq_8bit #(.CORE_LAT(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid0), .in_ready(in_ready0), .in_a(in_a0), .in_b(in_b0),
      .out_valid(out_valid0), .out_ready(out_ready0), .out_y(out_y0), .busy(busy0),
      .core_a(core_a0), .core_b(core_b0), .core_y(core_y0)
`ifdef OKA_SEQ_ACC_EN
      , .in_clr(in_clr0)
`endif
   );

   oka_seq_8bit #(.CORE_LAT(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid2), .in_ready(in_ready2), .in_a(in_a2), .in_b(in_b2),
      .out_valid(out_valid2), .out_ready(out_ready2), .out_y(out_y2), .busy(busy2),
      .core_a(core_a2), .core_b(core_b2), .core_y(core_y2)
`ifdef OKA_SEQ_ACC_EN
      , .in_clr(in_clr2)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      in_valid0 = 1'b0; in_a0 = '0; in_b0 = '0; out_ready0 = 1'b1;
      in_valid2 = 1'b0; in_a2 = '0; in_b2 = '0; out_ready2 = 1'b1;
`ifdef OKA_SEQ_ACC_EN
      in_clr0 = 1'b1; in_clr2 = 1'b1;
`endif
      tick; tick;

      chk("rst_out_valid", 32'(out_valid0), 32'd0);
      chk("rst_out_y",     32'(out_y0),     32'd0);
      chk("rst_busy",      32'(busy0),      32'd0);
      chk("rst_core_a",    32'(core_a0),    32'd0);
      chk("rst_core_b",    32'(core_b0),    32'd0);
      chk("rst_out_y2",    32'(out_y2),     32'd0);
      rst_n = 1'b1;
      tick;
      chk("post_rst_in_ready", 32'(in_ready0), 32'd1);

      // single product 0D x 0A, exact latency
      in_a0 = 8'h0D; in_b0 = 8'h0A; in_valid0 = 1'b1;
      tick;
      in_valid0 = 1'b0;
      chk("pl_busy",   32'(busy0),   32'd1);
      chk("pl_core_a", 32'(core_a0), 32'hD);
      chk("pl_core_b", 32'(core_b0), 32'hA);
      chk("pl_valid",  32'(out_valid0), 32'd0);
      tick;
      chk("ph_core_a", 32'(core_a0), 32'h0);
      chk("ph_valid",  32'(out_valid0), 32'd0);
      tick;
      chk("pm_core_a", 32'(core_a0), 32'hD);
      chk("pm_core_b", 32'(core_b0), 32'hA);
      chk("pm_valid",  32'(out_valid0), 32'd0);
      tick;
      chk("t3_valid",  32'(out_valid0), 32'd1);
      chk("t3_out_y",  32'(out_y0),     32'h0072);
      chk("done_core_a", 32'(core_a0),  32'h0);
      tick;
      chk("retire_busy",  32'(busy0),      32'd0);
      chk("retire_valid", 32'(out_valid0), 32'd0);

      // back-to-back FF x FF then 80 x 80; second pair presented while busy
      in_a0 = 8'hFF; in_b0 = 8'hFF; in_valid0 = 1'b1;
      tick;
      in_a0 = 8'h80; in_b0 = 8'h80;
      tick; tick; tick;
      chk("b2b1_valid",    32'(out_valid0), 32'd1);
      chk("b2b1_out_y",    32'(out_y0),     32'h5555);
      chk("b2b1_in_ready", 32'(in_ready0),  32'd1);
      tick;
      chk("b2b_no_bubble_busy",  32'(busy0),      32'd1);
      chk("b2b_no_bubble_valid", 32'(out_valid0), 32'd0);
      tick;
      chk("b2b2_ph_core_a", 32'(core_a0), 32'h8);
      tick; tick;
      chk("b2b2_valid", 32'(out_valid0), 32'd1);
      chk("b2b2_out_y", 32'(out_y0),     32'h4000);

      out_ready0 = 1'b0;
      in_a0 = 8'hA5; in_b0 = 8'h01;
      for (int k = 0; k < 5; k++) begin
         tick;
         chk("bp_out_y",     32'(out_y0),     32'h4000);
         chk("bp_in_ready",  32'(in_ready0),  32'd0);
         chk("bp_out_valid", 32'(out_valid0), 32'd1);
      end
      out_ready0 = 1'b1;
      tick;
      in_valid0 = 1'b0;
      tick; tick;
      chk("a5_early_valid", 32'(out_valid0), 32'd0);
      tick;
      chk("a5_valid", 32'(out_valid0), 32'd1);
      chk("a5_out_y", 32'(out_y0),     32'h00A5);
      tick;

      // reset during PH
      in_a0 = 8'h0D; in_b0 = 8'h0A; in_valid0 = 1'b1;
      tick;
      in_valid0 = 1'b0;
      tick;
      chk("midrst_pre_busy", 32'(busy0), 32'd1);
      rst_n = 1'b0;
      tick;
      chk("midrst_valid",  32'(out_valid0), 32'd0);
      chk("midrst_out_y",  32'(out_y0),     32'd0);
      chk("midrst_busy",   32'(busy0),      32'd0);
      chk("midrst_core_a", 32'(core_a0),    32'd0);
      chk("midrst_core_b", 32'(core_b0),    32'd0);
      rst_n = 1'b1;
      in_a0 = 8'h80; in_b0 = 8'h01; in_valid0 = 1'b1;
      tick;
      in_valid0 = 1'b0;
      tick; tick;
      chk("postrst_early_valid", 32'(out_valid0), 32'd0);
      tick;
      chk("postrst_valid", 32'(out_valid0), 32'd1);
      chk("postrst_out_y", 32'(out_y0),     32'h0080);
      tick;

      // CORE_LAT=2: each phase holds operands for 3 cycles, result after 9
      in_a2 = 8'h0D; in_b2 = 8'h0A; in_valid2 = 1'b1;
      tick;
      in_valid2 = 1'b0;
      for (int k = 0; k < 9; k++) begin
         chk("lat2_core_a", 32'(core_a2), (k / 3 == 1) ? 32'h0 : 32'hD);
         chk("lat2_core_b", 32'(core_b2), (k / 3 == 1) ? 32'h0 : 32'hA);
         chk("lat2_early_valid", 32'(out_valid2), 32'd0);
         tick;
      end
      chk("lat2_valid", 32'(out_valid2), 32'd1);
      chk("lat2_out_y", 32'(out_y2),     32'h0072);
      tick;
      chk("lat2_idle", 32'(busy2), 32'd0);

`ifdef OKA_SEQ_ACC_EN
      in_clr0 = 1'b1; in_a0 = 8'h0D; in_b0 = 8'h0A; in_valid0 = 1'b1;
      tick;
      in_valid0 = 1'b0;
      tick; tick; tick;
      chk("acc1_out_y", 32'(out_y0), 32'h0072);
      tick;
      in_clr0 = 1'b0; in_a0 = 8'h80; in_b0 = 8'h80; in_valid0 = 1'b1;
      tick;
      in_valid0 = 1'b0;
      tick; tick; tick;
      chk("acc2_valid", 32'(out_valid0), 32'd1);
      chk("acc2_out_y", 32'(out_y0),     32'h4072);
      tick;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
